stq_adata_drain: RTL and testbench
==================================

# stq_adata_drain

In-order drain reader for the 64-entry store-queue attribute table (`stq_adata`). It tracks which WQ slots have had attribute data written, walks the ring from a head pointer, and reads each written slot's 5-bit attribute data through one table read port. It presents the slots one at a time on a registered valid/ready output toward the store write-back path. It observes the same two write strobes that fill the table, so it always sees a slot as ready exactly when the table holds its data.

## Interface
- No parameters; the ring depth is fixed at 64 and attribute width at 5.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wrt0_en`  in  1  table write port 0 strobe; marks slot `wrt0_WQ` ready.
- `wrt0_WQ`  in  6  slot index for port 0.
- `wrt1_en`  in  1  table write port 1 strobe; marks slot `wrt1_WQ` ready.
- `wrt1_WQ`  in  6  slot index for port 1.
- `rd_WQ`  out  6  table read index; always equals `head`; combinational.
- `rd_adata`  in  5  table read data for `rd_WQ`; combinational return in the same cycle.
- `flush_en`  in  1  synchronous pipeline flush.
- `flush_WQ`  in  6  new head index on flush.
- `out_vld`  out  1  output holds a drained slot.
- `out_rdy`  in  1  consumer accepts the output this cycle.
- `out_WQ`  out  6  slot index of the drained entry.
- `out_adata`  out  5  attribute data of the drained entry.
- `out_par`  out  1  parity bit; present only with `STQ_DRAIN_PARITY_EN`.
- `pend_cnt`  out  7  number of ready, undrained slots (0..64).

## Operation
- **State:**
  - `ready[63:0]` bitmap.
  - `head[5:0]`.
  - Output register: `out_vld`, `out_WQ`, `out_adata`, `out_par`.
  - `pend_cnt[6:0]`.
- **Set:** each enabled write port sets `ready[WQ]`. If both ports write the same index in the same cycle, the bit is set once.
- **Advance condition:** `adv = ready[head] & (~out_vld | out_rdy) & ~flush_en`.
- **On adv:**
  - Output register loads `out_WQ <= head`, `out_adata <= rd_adata`, and `out_vld <= 1`.
  - `ready[head]` is cleared.
  - `head <= head + 1` modulo 64 (63 wraps to 0).
- **Consume without advance:** when `out_vld & out_rdy & ~adv`, `out_vld <= 0`. `out_WQ` and `out_adata` hold their last values.
- **Stall:** when `out_vld & ~out_rdy`, all output fields hold stable, and `head` and the head ready bit are unchanged.
- **Set/clear collision:** if a write strobe targets `head` in the same cycle that `adv` clears it, the set wins and the bit stays 1, because the slot has been re-allocated after a wrap.
- **pend_cnt:**
  - Incremented by the number of distinct writes to bits that were previously 0.
  - Decremented by 1 on `adv`, unless a set-wins collision keeps the bit at 1.
  - Always equals popcount(`ready`).
- **Flush:**
  - `ready` clears to 0, `out_vld` goes to 0, `pend_cnt` goes to 0, and `head` loads `flush_WQ`.
  - Writes presented in the flush cycle are dropped.
  - A pending output is discarded even if `out_rdy` is high.
- **Reset:** `head=0`, `ready=0`, `out_vld=0`, `out_WQ=0`, `out_adata=0`, `out_par=0`, `pend_cnt=0`.
- **Asynchronous reset mid-transfer:** all state returns to the reset values immediately, and no partial output is retained.

## Timing
- Table write and ready-bit set land on the same edge (end of cycle N).
- The drain reads `rd_adata` combinationally in cycle N+1; `out_vld` is visible from cycle N+2. Write-to-output latency is 2 cycles.
- Throughput is one slot per cycle while `out_rdy` is held high and consecutive slots are ready.
- Draining is strictly in order: a non-ready head blocks later ready slots (head-of-line).
- `rd_WQ` changes only on a clock edge, as `head` changes.
- `pend_cnt` is registered and reflects state after the previous edge.

## Configuration
- **`STQ_DRAIN_PARITY_EN` defined:** `out_par` exists and is registered with the output. It equals `^{out_WQ, out_adata}`, i.e. even parity over the 11 bits, and its reset value is 0.
- **Not defined:** the `out_par` port and its logic are absent; all other behaviour is identical.

## Test plan
- **Basic drain:** reset; write slot 0 with adata=5'h1A at cycle 1 → `out_vld`=1, `out_WQ`=0, `out_adata`=5'h1A at cycle 3; `pend_cnt` reads 1 then 0.
- **Streaming with backpressure:** write slots 0..3 on consecutive cycles; hold `out_rdy`=0 for 3 cycles, then 1 → output holds slot 0 stable during the stall, then slots 0,1,2,3 appear back-to-back; `head`=4.
- **Head-of-line block:** write slots 1 and 2, but not 0 → `out_vld` stays 0. Then write slot 0 → outputs appear in order 0, 1, 2.
- **Wrap and set-wins collision:** flush to `flush_WQ`=63; write slot 63 and then slot 0 → outputs in order 63 then 0. Separately, write the head slot in the same cycle it drains → ready stays 1, `pend_cnt` is unchanged, and the slot drains again after the wrap.
- **Flush:** slots 4..6 ready with `out_vld`=1 and `flush_en`=1, `flush_WQ`=10, plus a simultaneous write to slot 10 → next cycle `out_vld`=0, `pend_cnt`=0, `head`=10, and slot 10 is not ready.
- **Parity and reset:** with `STQ_DRAIN_PARITY_EN`, `out_WQ`=6'h05, `out_adata`=5'h03 → `out_par`=0. Assert `rst` while `out_vld`=1 → all outputs go to 0 immediately.

Source files
------------

// File: rtl/stq_adata_drain.sv
// ============================================================================
// stq_adata_drain
// ----------------------------------------------------------------------------
// In-order drain reader for the 64-entry store-queue attribute table.
// A ready bitmap records which WQ slots the table has written. The drain
// walks the ring from `head` and reads each written slot through the table's
// single read port. It then presents that slot on a registered valid/ready
// output toward store write-back. Because the bitmap watches the same two
// write strobes that fill the table, a slot becomes ready on the same edge
// that its data lands.
//
// Optional feature macro: STQ_DRAIN_PARITY_EN
//   When defined, the design adds the `out_par` output. It is registered with
//   the output fields and carries even parity over {out_WQ, out_adata}.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   wrt0_en    in   1  table write port 0 strobe
//   wrt0_WQ    in   6  slot written by port 0
//   wrt1_en    in   1  table write port 1 strobe
//   wrt1_WQ    in   6  slot written by port 1
//   rd_WQ      out  6  table read index (always equals head)
//   rd_adata   in   5  table read data for rd_WQ, same cycle
//   flush_en   in   1  synchronous flush
//   flush_WQ   in   6  head index loaded on flush
//   out_vld    out  1  output register holds a drained slot
//   out_rdy    in   1  consumer accepts the output this cycle
//   out_WQ     out  6  slot index of the drained entry
//   out_adata  out  5  attribute data of the drained entry
//   out_par    out  1  even parity of {out_WQ, out_adata} (parity build only)
//   pend_cnt   out  7  number of ready, undrained slots (0..64)
// ============================================================================
module stq_adata_drain (
    input  logic       clk,
    input  logic       rst,
    input  logic       wrt0_en,
    input  logic [5:0] wrt0_WQ,
    input  logic       wrt1_en,
    input  logic [5:0] wrt1_WQ,
    output logic [5:0] rd_WQ,
    input  logic [4:0] rd_adata,
    input  logic       flush_en,
    input  logic [5:0] flush_WQ,
    output logic       out_vld,
    input  logic       out_rdy,
    output logic [5:0] out_WQ,
    output logic [4:0] out_adata,
`ifdef STQ_DRAIN_PARITY_EN
    output logic       out_par,
`endif
    output logic [6:0] pend_cnt
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [63:0] ready_q,     ready_d;
    logic [5:0]  head_q,      head_d;
    logic        out_vld_q,   out_vld_d;
    logic [5:0]  out_wq_q,    out_wq_d;
    logic [4:0]  out_adata_q, out_adata_d;
    logic [6:0]  pend_cnt_q,  pend_cnt_d;
`ifdef STQ_DRAIN_PARITY_EN
    logic        out_par_q,   out_par_d;
`endif

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [63:0] set_mask;
    logic        adv;
    logic        head_set;   // a write strobe targets the head slot this cycle
    logic [6:0]  n_new;      // distinct writes to bits that were 0

    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves a variable unassigned would infer a latch.
        set_mask = '0;
        n_new    = '0;

        if (wrt0_en) set_mask[wrt0_WQ] = 1'b1;
        if (wrt1_en) set_mask[wrt1_WQ] = 1'b1;

        if (wrt0_en && !ready_q[wrt0_WQ])
            n_new = n_new + 7'd1;
        // When both ports hit the same slot, count that slot only once.
        if (wrt1_en && !ready_q[wrt1_WQ] && !(wrt0_en && (wrt0_WQ == wrt1_WQ)))
            n_new = n_new + 7'd1;

        head_set = set_mask[head_q];
        adv      = ready_q[head_q] & (~out_vld_q | out_rdy) & ~flush_en;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        ready_d     = ready_q;
        head_d      = head_q;
        out_vld_d   = out_vld_q;
        out_wq_d    = out_wq_q;
        out_adata_d = out_adata_q;
        pend_cnt_d  = pend_cnt_q;
`ifdef STQ_DRAIN_PARITY_EN
        out_par_d   = out_par_q;
`endif

        if (flush_en) begin
            // A flush drops the pending output and any writes in this cycle.
            ready_d    = '0;
            out_vld_d  = 1'b0;
            pend_cnt_d = '0;
            head_d     = flush_WQ;
        end else begin
            if (adv) begin
                out_vld_d   = 1'b1;
                out_wq_d    = head_q;
                out_adata_d = rd_adata;
`ifdef STQ_DRAIN_PARITY_EN
                out_par_d   = ^{head_q, rd_adata};
`endif
                ready_d[head_q] = 1'b0;
                head_d          = head_q + 6'd1;   // 6-bit add wraps 63 -> 0
            end else if (out_vld_q && out_rdy) begin
                out_vld_d = 1'b0;
            end

            // The set is applied after the clear, so a re-allocated head slot
            // (written in the cycle it drains) stays ready.
            ready_d = ready_d | set_mask;

            pend_cnt_d = pend_cnt_q + n_new
                       - {6'd0, (adv && !head_set)};
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // The 64-bit bitmap is reset explicitly. It is a flop array, not
            // a RAM, and a stale ready bit would drain garbage after reset.
            ready_q     <= '0;
            head_q      <= '0;
            out_vld_q   <= 1'b0;
            out_wq_q    <= '0;
            out_adata_q <= '0;
            pend_cnt_q  <= '0;
`ifdef STQ_DRAIN_PARITY_EN
            out_par_q   <= 1'b0;
`endif
        end else begin
            ready_q     <= ready_d;
            head_q      <= head_d;
            out_vld_q   <= out_vld_d;
            out_wq_q    <= out_wq_d;
            out_adata_q <= out_adata_d;
            pend_cnt_q  <= pend_cnt_d;
`ifdef STQ_DRAIN_PARITY_EN
            out_par_q   <= out_par_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rd_WQ     = head_q;
    assign out_vld   = out_vld_q;
    assign out_WQ    = out_wq_q;
    assign out_adata = out_adata_q;
    assign pend_cnt  = pend_cnt_q;
`ifdef STQ_DRAIN_PARITY_EN
    assign out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_stq_adata_drain.sv
// Testbench for stq_adata_drain. It applies directed scenarios followed by
// random traffic. Every cycle is checked against a behavioural model: a
// ready set, a head pointer and a one-deep output slot, with pend_cnt taken
// as the population count of the ready set.
module tb_stq_adata_drain;

    logic       clk = 1'b0;
    logic       rst;
    logic       wrt0_en, wrt1_en;
    logic [5:0] wrt0_WQ, wrt1_WQ;
    logic [5:0] rd_WQ;
    wire  [4:0] rd_adata;
    logic       flush_en;
    logic [5:0] flush_WQ;
    logic       out_vld;
    logic       out_rdy;
    logic [5:0] out_WQ;
    logic [4:0] out_adata;
    logic [6:0] pend_cnt;
`ifdef STQ_DRAIN_PARITY_EN
    logic       out_par;
`endif

    always #5 clk = ~clk;

    stq_adata_drain dut (
        .clk       (clk),
        .rst       (rst),
        .wrt0_en   (wrt0_en),
        .wrt0_WQ   (wrt0_WQ),
        .wrt1_en   (wrt1_en),
        .wrt1_WQ   (wrt1_WQ),
        .rd_WQ     (rd_WQ),
        .rd_adata  (rd_adata),
        .flush_en  (flush_en),
        .flush_WQ  (flush_WQ),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_WQ    (out_WQ),
        .out_adata (out_adata),
`ifdef STQ_DRAIN_PARITY_EN
        .out_par   (out_par),
`endif
        .pend_cnt  (pend_cnt)
    );

    // Attribute table behind the read port (written at the clock edge).
    logic [4:0] tbl [64];
    assign rd_adata = tbl[rd_WQ];

    // Reference model
    bit         m_ready [64];
    logic [5:0] m_head;
    bit         m_vld;
    logic [5:0] m_wq;
    logic [4:0] m_adata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int m_pend();
        int c = 0;
        for (int i = 0; i < 64; i++) c += int'(m_ready[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_ready[i] = 1'b0;
        m_head  = '0;
        m_vld   = 1'b0;
        m_wq    = '0;
        m_adata = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".vld"},   {31'd0, out_vld}, {31'd0, m_vld});
        check({tag, ".pend"},  {25'd0, pend_cnt}, m_pend());
        check({tag, ".rd_WQ"}, {26'd0, rd_WQ},    {26'd0, m_head});
        if (m_vld) begin
            check({tag, ".WQ"},    {26'd0, out_WQ},    {26'd0, m_wq});
            check({tag, ".adata"}, {27'd0, out_adata}, {27'd0, m_adata});
`ifdef STQ_DRAIN_PARITY_EN
            check({tag, ".par"},   {31'd0, out_par},   {31'd0, ^{m_wq, m_adata}});
`endif
        end
    endtask

    // One clock cycle. It is entered at posedge+1: inputs are driven, the
    // registered outputs are checked, the model advances, and the task
    // returns at the next posedge+1.
    task automatic step(input string tag,
                        input bit w0e, input logic [5:0] w0, input logic [4:0] d0,
                        input bit w1e, input logic [5:0] w1, input logic [4:0] d1,
                        input bit rdy, input bit fe, input logic [5:0] fw);
        bit adv;
        wrt0_en = w0e; wrt0_WQ = w0;
        wrt1_en = w1e; wrt1_WQ = w1;
        out_rdy = rdy; flush_en = fe; flush_WQ = fw;
        #1;
        check_outputs(tag);
        adv = m_ready[m_head] && (!m_vld || rdy) && !fe;
        if (fe) begin
            for (int i = 0; i < 64; i++) m_ready[i] = 1'b0;
            m_vld  = 1'b0;
            m_head = fw;
        end else begin
            if (adv) begin
                m_wq    = m_head;
                m_adata = tbl[m_head];
                m_vld   = 1'b1;
                m_ready[m_head] = 1'b0;
                m_head  = m_head + 6'd1;
            end else if (m_vld && rdy) begin
                m_vld = 1'b0;
            end
            if (w0e) m_ready[w0] = 1'b1;
            if (w1e) m_ready[w1] = 1'b1;
        end
        @(posedge clk);
        #1;
        if (w0e) tbl[w0] = d0;
        if (w1e) tbl[w1] = d1;
    endtask

    task automatic wr1(input string tag, input logic [5:0] s, input logic [4:0] d, input bit rdy);
        step(tag, 1'b1, s, d, 1'b0, 6'd0, 5'd0, rdy, 1'b0, 6'd0);
    endtask

    task automatic idle(input string tag, input bit rdy);
        step(tag, 1'b0, 6'd0, 5'd0, 1'b0, 6'd0, 5'd0, rdy, 1'b0, 6'd0);
    endtask

    task automatic flush(input string tag, input logic [5:0] fw);
        step(tag, 1'b0, 6'd0, 5'd0, 1'b0, 6'd0, 5'd0, 1'b1, 1'b1, fw);
    endtask

    initial begin
        bit         re0, re1, rrdy, rfl;
        logic [5:0] rw0, rw1, rfw;
        logic [4:0] rd0, rd1;

        rst = 1'b1;
        wrt0_en = 0; wrt0_WQ = 0; wrt1_en = 0; wrt1_WQ = 0;
        out_rdy = 0; flush_en = 0; flush_WQ = 0;
        for (int i = 0; i < 64; i++) tbl[i] = 5'(i + 3);
        model_reset();

        // Reset state
        #12;
        check("rst.vld",   {31'd0, out_vld},   0);
        check("rst.WQ",    {26'd0, out_WQ},    0);
        check("rst.adata", {27'd0, out_adata}, 0);
        check("rst.pend",  {25'd0, pend_cnt},  0);
        check("rst.rd_WQ", {26'd0, rd_WQ},     0);
`ifdef STQ_DRAIN_PARITY_EN
        check("rst.par",   {31'd0, out_par},   0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic drain: 2-cycle write-to-output latency
        wr1("basic.w", 6'd0, 5'h1A, 1'b1);
        check("basic.pend1", {25'd0, pend_cnt}, 1);
        check("basic.vld0",  {31'd0, out_vld},  0);
        idle("basic.i", 1'b1);
        check("basic.vld1",  {31'd0, out_vld},   1);
        check("basic.WQ",    {26'd0, out_WQ},    0);
        check("basic.adata", {27'd0, out_adata}, 32'h1A);
        check("basic.pend0", {25'd0, pend_cnt},  0);

        // Streaming with backpressure
        flush("stream.f", 6'd0);
        wr1("stream.w0", 6'd0, 5'h11, 1'b0);
        wr1("stream.w1", 6'd1, 5'h12, 1'b0);
        wr1("stream.w2", 6'd2, 5'h13, 1'b0);
        wr1("stream.w3", 6'd3, 5'h14, 1'b0);
        idle("stream.stall", 1'b0);
        for (int i = 0; i < 6; i++) idle("stream.go", 1'b1);
        check("stream.head", {26'd0, rd_WQ}, 4);

        // Head-of-line block
        flush("hol.f", 6'd0);
        wr1("hol.w1", 6'd1, 5'h05, 1'b1);
        wr1("hol.w2", 6'd2, 5'h06, 1'b1);
        idle("hol.blk", 1'b1);
        idle("hol.blk", 1'b1);
        check("hol.vld0", {31'd0, out_vld}, 0);
        check("hol.pend", {25'd0, pend_cnt}, 2);
        wr1("hol.w0", 6'd0, 5'h07, 1'b1);
        for (int i = 0; i < 5; i++) idle("hol.go", 1'b1);

        // Wrap 63 -> 0
        flush("wrap.f", 6'd63);
        wr1("wrap.w63", 6'd63, 5'h09, 1'b1);
        wr1("wrap.w0",  6'd0,  5'h0A, 1'b1);
        idle("wrap.i", 1'b1);
        check("wrap.WQ0", {26'd0, out_WQ}, 0);
        for (int i = 0; i < 3; i++) idle("wrap.i", 1'b1);

        // Set-wins collision: slot 0 re-written as it drains
        flush("coll.f", 6'd0);
        wr1("coll.w", 6'd0, 5'h0B, 1'b1);
        wr1("coll.hit", 6'd0, 5'h0C, 1'b1);
        check("coll.pend", {25'd0, pend_cnt}, 1);
        for (int i = 1; i < 64; i += 2)
            step("coll.fill", 1'b1, 6'(i), 5'(i), (i < 63), 6'(i + 1), 5'(i + 1),
                 1'b1, 1'b0, 6'd0);
        for (int i = 0; i < 40; i++) idle("coll.drain", 1'b1);
        check("coll.empty", {25'd0, pend_cnt}, 0);

        // Flush with a pending output and a simultaneous write
        flush("fl.f", 6'd4);
        wr1("fl.w4", 6'd4, 5'h01, 1'b0);
        wr1("fl.w5", 6'd5, 5'h02, 1'b0);
        wr1("fl.w6", 6'd6, 5'h03, 1'b0);
        check("fl.vld1", {31'd0, out_vld}, 1);
        step("fl.fl", 1'b1, 6'd10, 5'h1F, 1'b0, 6'd0, 5'd0, 1'b1, 1'b1, 6'd10);
        check("fl.vld0", {31'd0, out_vld},  0);
        check("fl.pend", {25'd0, pend_cnt}, 0);
        check("fl.head", {26'd0, rd_WQ},    10);
        idle("fl.i", 1'b1);
        idle("fl.i", 1'b1);
        check("fl.no10", {31'd0, out_vld}, 0);

`ifdef STQ_DRAIN_PARITY_EN
        // Parity example
        flush("par.f", 6'd5);
        wr1("par.w", 6'd5, 5'h03, 1'b1);
        idle("par.i", 1'b1);
        check("par.WQ",  {26'd0, out_WQ},    5);
        check("par.ad",  {27'd0, out_adata}, 3);
        check("par.par", {31'd0, out_par},   0);
`endif

        // Asynchronous reset with an output pending
        flush("ar.f", 6'd0);
        wr1("ar.w", 6'd0, 5'h07, 1'b0);
        idle("ar.i", 1'b0);
        check("ar.vld1", {31'd0, out_vld}, 1);
        rst = 1'b1;
        #1;
        check("ar.vld",   {31'd0, out_vld},   0);
        check("ar.WQ",    {26'd0, out_WQ},    0);
        check("ar.adata", {27'd0, out_adata}, 0);
        check("ar.pend",  {25'd0, pend_cnt},  0);
        check("ar.rd_WQ", {26'd0, rd_WQ},     0);
`ifdef STQ_DRAIN_PARITY_EN
        check("ar.par",   {31'd0, out_par},   0);
`endif
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            re0  = ($urandom_range(0, 2) != 0);
            re1  = ($urandom_range(0, 2) == 0);
            rw0  = 6'($urandom_range(0, 63));
            rw1  = ($urandom_range(0, 3) == 0) ? rw0 : 6'($urandom_range(0, 63));
            rd0  = 5'($urandom_range(0, 31));
            rd1  = (rw1 == rw0) ? rd0 : 5'($urandom_range(0, 31));
            rrdy = ($urandom_range(0, 3) != 0);
            rfl  = ($urandom_range(0, 40) == 0);
            rfw  = 6'($urandom_range(0, 63));
            step("rnd", re0, rw0, rd0, re1, rw1, rd1, rrdy, rfl, rfw);
        end
        idle("rnd.end", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
